stream_decrypt_rx: RTL and testbench

Receive-side decryptor for the secured serial link. It takes ciphertext bytes from the UART receiver and XORs each one with a keystream byte from its own 128-bit LFSR, which runs in lock-step with the transmit-side keystream generator. Plaintext bytes are buffered in a small output FIFO with a valid/ready handshake. The block sits between the UART RX deserializer and the consuming logic, at the 3.125 MHz system clock.

---
 rtl/secure_link_pkg.sv | 24 ++
 rtl/keystream_lfsr.sv | 25 ++
 rtl/stream_decrypt_rx.sv | 142 ++++++++++++++
 tb/tb_stream_decrypt_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/secure_link_pkg.sv
// Shared definitions for the secured serial link.
// Keystream key, LFSR taps and the step function used by both link ends.
package secure_link_pkg;

    localparam logic [127:0] MASTER_KEY_DEFAULT =
        128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;

    localparam int TAP_A = 127;
    localparam int TAP_B = 29;
    localparam int TAP_C = 27;
    localparam int TAP_D = 2;

    typedef enum logic {
        RX_IDLE,
        RX_ADV
    } rx_state_e;

    function automatic logic [127:0] lfsr_step(input logic [127:0] s);
        logic fb;
        fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
        return {fb, s[127:1]};
    endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// 128-bit keystream LFSR, shared by the receive and transmit link ends.
// load has priority over step; reset loads the master key.
module keystream_lfsr
    import secure_link_pkg::*;
#(
    parameter logic [127:0] MASTER_KEY = MASTER_KEY_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    output logic [127:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MASTER_KEY;
        end else if (load) begin
            state <= MASTER_KEY;
        end else if (step) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/stream_decrypt_rx.sv
// Receive-side stream decryptor: XOR with LFSR keystream, 8-step advance
// per byte, plaintext buffered in a small valid/ready FIFO.
module stream_decrypt_rx
    import secure_link_pkg::*;
#(
    parameter int           FIFO_DEPTH = 4,
    parameter logic [127:0] MASTER_KEY = MASTER_KEY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resync,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        overrun,
    output logic [31:0] byte_count,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    rx_state_e     state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          step;
    logic          accept;
    logic [127:0]  lfsr_state;
    logic [7:0]    plain;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;

    keystream_lfsr #(
        .MASTER_KEY(MASTER_KEY)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (resync),
        .step (step),
        .state(lfsr_state)
    );

    assign plain     = in_data ^ lfsr_state[7:0];
    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready && !resync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        step     = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                in_ready = !full;
                if (in_valid && !full && !resync) begin
                    accept  = 1'b1;
                    state_d = RX_ADV;
                    cnt_d   = '0;
                end
            end
            RX_ADV: begin
                busy  = 1'b1;
                step  = !resync;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = RX_IDLE;
                end
            end
        endcase
        // resync aborts any advance in flight
        if (resync) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (resync) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= plain;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun    <= 1'b0;
            byte_count <= '0;
        end else if (resync) begin
            overrun    <= 1'b0;
            byte_count <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                byte_count <= byte_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_stream_decrypt_rx.sv
// Directed bench for stream_decrypt_rx with a transmit-side keystream
// model for the loopback run.
module tb_stream_decrypt_rx;

    localparam logic [127:0] KEY = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        resync;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        overrun;
    logic [31:0] byte_count;
    logic        busy;

    int errs   = 0;
    int checks = 0;

    always #160 clk = ~clk;

    stream_decrypt_rx #(
        .FIFO_DEPTH(4),
        .MASTER_KEY(KEY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .resync    (resync),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overrun   (overrun),
        .byte_count(byte_count),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic do_resync();
        resync = 1'b1;
        tick(1);
        resync = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_v"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    function automatic logic [127:0] tx_step(input logic [127:0] s);
        logic fb;
        fb = s[127] ^ s[29] ^ s[27] ^ s[2];
        return {fb, s[127:1]};
    endfunction

    logic [7:0]   pats [5];
    logic [7:0]   exps [4];
    logic [127:0] tx;
    logic [7:0]   pt;
    logic [7:0]   ct;

    initial begin
        rst_n     = 1'b0;
        resync    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_byte_count", byte_count, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // first byte: key EF
        send(8'hEF);
        chk("t1_data", 32'(out_data), 32'h00);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_count", byte_count, 32'd1);
        chk("t1_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t1_busy_%0d", i), 32'(busy), 32'd1);
            tick(1);
        end
        chk("t1_busy_done", 32'(busy), 32'd0);
        chk("t1_in_ready_back", 32'(in_ready), 32'd1);
        pop_chk("t1_pop", 8'h00);
        chk("t1_empty", 32'(out_valid), 32'd0);

        // three bytes, keys EF CD AB
        do_resync();
        for (int i = 0; i < 3; i++) begin
            send(8'h41);
            tick(8);
        end
        chk("t2_count", byte_count, 32'd3);
        pop_chk("t2_b0", 8'hAE);
        pop_chk("t2_b1", 8'h8C);
        pop_chk("t2_b2", 8'hEA);
        chk("t2_empty", 32'(out_valid), 32'd0);

        // FIFO full then overrun
        do_resync();
        pats = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        exps = '{8'hFF, 8'hED, 8'h9B, 8'hC9};
        for (int i = 0; i < 4; i++) begin
            send(pats[i]);
            tick(8);
        end
        chk("t3_full_in_ready", 32'(in_ready), 32'd0);
        chk("t3_no_overrun_yet", 32'(overrun), 32'd0);
        send(pats[4]);
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_count", byte_count, 32'd4);
        chk("t3_not_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pop_chk($sformatf("t3_drain_%0d", i), exps[i]);
        end
        chk("t3_empty", 32'(out_valid), 32'd0);
        chk("t3_in_ready", 32'(in_ready), 32'd1);

        // byte during ADV is dropped
        do_resync();
        send(8'h00);
        chk("t4_first", 32'(out_data), 32'hEF);
        tick(2);
        send(8'h55);
        chk("t4_overrun", 32'(overrun), 32'd1);
        chk("t4_count", byte_count, 32'd1);
        tick(8);
        do_resync();
        chk("t4_rs_overrun", 32'(overrun), 32'd0);
        chk("t4_rs_count", byte_count, 32'd0);
        chk("t4_rs_empty", 32'(out_valid), 32'd0);
        send(8'hEF);
        chk("t4_rs_data", 32'(out_data), 32'h00);
        tick(8);

        // resync at ADV counter 4 with 2 bytes buffered
        do_resync();
        send(8'h01);
        tick(8);
        send(8'h02);
        tick(4);
        chk("t5_busy_mid", 32'(busy), 32'd1);
        do_resync();
        chk("t5_empty", 32'(out_valid), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_count", byte_count, 32'd0);
        send(8'h00);
        chk("t5_key_reload", 32'(out_data), 32'hEF);
        tick(8);
        pop_chk("t5_pop", 8'hEF);

        // async reset mid-advance
        send(8'h33);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_empty", 32'(out_valid), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_count", byte_count, 32'd0);
        tick(1);
        rst_n = 1'b1;
        send(8'hEF);
        chk("t6_key_reload", 32'(out_data), 32'h00);
        tick(8);
        pop_chk("t6_pop", 8'h00);

        // loopback against transmit-side keystream model
        do_resync();
        tx        = KEY;
        out_ready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            pt = 8'($urandom_range(0, 255));
            ct = pt ^ tx[7:0];
            for (int k = 0; k < 8; k++) begin
                tx = tx_step(tx);
            end
            send(ct);
            chk($sformatf("lb_v_%0d", n), 32'(out_valid), 32'd1);
            chk($sformatf("lb_d_%0d", n), 32'(out_data), 32'(pt));
            tick(8);
        end
        out_ready = 1'b0;
        chk("lb_overrun", 32'(overrun), 32'd0);
        chk("lb_count", byte_count, 32'd256);
        chk("lb_empty", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
